burst_sequencer: RTL
====================

BURST_SEQUENCER -- requirements
Module: burst_sequencer

Interface
REQ-001 Parameter LEN_W, default 8, width of burst length and period count.
REQ-002 Parameter WDOG_CYCLES, default 16, maximum RUN cycles allowed between counter done pulses.
REQ-003 i_clk  input  1  system clock; the only clock, all state on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_start_valid  input  1  burst request valid.
REQ-006 o_start_ready  output  1  request accepted when o_start_ready and i_start_valid are both high at a rising edge.
REQ-007 i_burst_len  input  LEN_W  number of counter periods requested; sampled only on acceptance.
REQ-008 i_abort  input  1  abort request; honoured in RUN only.
REQ-009 o_cnt_ena  output  1  registered enable driven to the downstream 10-cycle counter.
REQ-010 i_cnt_done  input  1  counter terminal-count flag (high when count==9).
REQ-011 o_busy  output  1  high in RUN.
REQ-012 o_cmplt  output  1  one-cycle pulse: burst finished normally.
REQ-013 o_aborted  output  1  one-cycle pulse: burst ended by i_abort.
REQ-014 o_err  output  1  one-cycle pulse: watchdog expired.
REQ-015 o_periods  output  LEN_W  periods completed in current or last burst.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, CMPLT, ABORT, ERR; every output except o_periods is a decode of the registered state.
REQ-017 o_start_ready SHALL be high in IDLE only.
REQ-018 On acceptance with i_burst_len!=0: latch length, clear o_periods and watchdog, enter RUN next cycle.
REQ-019 On acceptance with i_burst_len==0: go to CMPLT directly; o_cnt_ena never asserts, o_periods stays 0.
REQ-020 o_cnt_ena and o_busy SHALL be high exactly while in RUN.
REQ-021 In RUN, each cycle with i_cnt_done high SHALL increment o_periods (no wrap, saturate at latched length) and clear the watchdog.
REQ-022 When i_cnt_done is high and o_periods+1 equals the latched length: next state CMPLT; with a healthy counter RUN lasts exactly 10*length cycles.
REQ-023 i_abort high in RUN (and not REQ-022 final edge) SHALL move to ABORT; final-period completion wins over a simultaneous abort.
REQ-024 The watchdog SHALL count RUN cycles since the last i_cnt_done; reaching WDOG_CYCLES SHALL move to ERR; completion and abort take priority over ERR on the same edge.
REQ-025 CMPLT, ABORT, ERR SHALL each last one cycle then return to IDLE; a new request is accepted only from IDLE.
REQ-026 i_cnt_done outside RUN SHALL be ignored; i_abort outside RUN SHALL be ignored.
REQ-027 o_periods SHALL hold its value from burst end until the next acceptance.

Reset
REQ-028 On i_rst_n low: state IDLE, o_periods 0, watchdog 0, latched length 0, so o_cnt_ena=0, o_busy=0, pulses 0, o_start_ready=1.
REQ-029 Reset mid-RUN SHALL drop o_cnt_ena immediately (asynchronously) and produce no completion/abort/error pulse.
REQ-030 Release of reset SHALL take effect on the first rising edge after deassertion; no request accepted before that edge.

Structure
REQ-031 Shared package counter_pkg SHALL hold the state enum seq_state_e and constant PERIOD_CYCLES=10 used by benches.
REQ-032 Watchdog SHALL be a sub-module seq_watchdog (clear, enable, expired) parameterised by WDOG_CYCLES.
REQ-033 No combinational path from any input to any output except o_start_ready via state.

Verification
REQ-034 Start len=3 with real counter attached -> o_busy high 30 cycles, o_periods 1,2,3, single o_cmplt pulse, o_cnt_ena low after.
REQ-035 Start len=0 -> o_cmplt pulse one cycle after acceptance, o_cnt_ena never high, o_periods=0.
REQ-036 Start len=5, i_abort at RUN cycle 23 -> o_aborted pulse, o_periods=2, o_cnt_ena low next cycle.
REQ-037 Start len=2, i_abort on same edge as second i_cnt_done -> o_cmplt pulse, no o_aborted, o_periods=2.
REQ-038 Start len=4, counter model stuck (i_cnt_done=0) -> o_err pulse after 16 RUN cycles, o_periods=0.
REQ-039 Reset asserted mid-burst len=8 -> all outputs at reset values immediately, o_start_ready=1 after release, fresh len=1 burst completes in 10 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the burst sequencer and the 10-cycle counter it drives.
package counter_pkg;

    // Sequencer states; the top keeps the raw encoding as plain constants.
    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_RUN   = 3'd1,
        SEQ_CMPLT = 3'd2,
        SEQ_ABORT = 3'd3,
        SEQ_ERR   = 3'd4
    } seq_state_e;

    // Length of one downstream counter period (count 0..9).
    localparam int PERIOD_CYCLES = 10;

    // RUN duration of an undisturbed burst with a healthy counter.
    function automatic int burst_run_cycles(input int len);
        return len * PERIOD_CYCLES;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog: counts enabled cycles since the last clear. It flags expiry during
// the WDOG_CYCLES-th enabled cycle with no clear, so the owner can leave on
// that edge.
module seq_watchdog #(
    parameter int WDOG_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Clear wins; otherwise count enabled cycles and stick at the limit.
    always_comb begin
        count_next = count_reg;
        if (i_clear) begin
            count_next = '0;
        end else if (i_enable && (count_reg != LIMIT)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Expiry only matters while the owner is actually running.
    assign o_expired = i_enable && (count_reg == LIMIT);

endmodule

// File: rtl/burst_sequencer.sv
// Burst sequencer: accepts a burst length, enables a 10-cycle counter for that
// many periods, and reports normal completion, abort or watchdog error with a
// one-cycle pulse. All control outputs are decodes of the registered state.
module burst_sequencer
    import counter_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int WDOG_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic             i_abort,
    output logic             o_cnt_ena,
    input  logic             i_cnt_done,
    output logic             o_busy,
    output logic             o_cmplt,
    output logic             o_aborted,
    output logic             o_err,
    output logic [LEN_W-1:0] o_periods
);

    localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
    localparam logic [2:0] ST_RUN   = SEQ_RUN;
    localparam logic [2:0] ST_CMPLT = SEQ_CMPLT;
    localparam logic [2:0] ST_ABORT = SEQ_ABORT;
    localparam logic [2:0] ST_ERR   = SEQ_ERR;

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] periods_reg;
    logic [LEN_W-1:0] periods_next;

    logic             accept;
    logic             in_run;
    logic             done_run;
    logic [LEN_W:0]   periods_inc;
    logic             final_done;
    logic             wdog_expired;

    assign accept   = (state_reg == ST_IDLE) && i_start_valid;
    assign in_run   = (state_reg == ST_RUN);
    assign done_run = in_run && i_cnt_done;

    // One bit wider so the compare against the length cannot wrap at max length.
    assign periods_inc = {1'b0, periods_reg} + (LEN_W + 1)'(1);
    assign final_done  = done_run && (periods_inc == {1'b0, len_reg});

    seq_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (accept || done_run),
        .i_enable  (in_run),
        .o_expired (wdog_expired)
    );

    // Next state: final period beats abort, abort beats watchdog, and a done
    // pulse on its own keeps the burst alive.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start_valid) begin
                    state_next = (i_burst_len == '0) ? ST_CMPLT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (final_done) begin
                    state_next = ST_CMPLT;
                end else if (i_abort) begin
                    state_next = ST_ABORT;
                end else if (i_cnt_done) begin
                    state_next = ST_RUN;
                end else if (wdog_expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_CMPLT, ST_ABORT, ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Length latch and period count; the count holds once the burst ends.
    always_comb begin
        len_next     = len_reg;
        periods_next = periods_reg;
        if (accept) begin
            len_next     = i_burst_len;
            periods_next = '0;
        end else if (done_run && (periods_inc <= {1'b0, len_reg})) begin
            periods_next = periods_inc[LEN_W-1:0];
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            len_reg     <= '0;
            periods_reg <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            periods_reg <= periods_next;
        end
    end

    assign o_start_ready = (state_reg == ST_IDLE);
    assign o_cnt_ena     = in_run;
    assign o_busy        = in_run;
    assign o_cmplt       = (state_reg == ST_CMPLT);
    assign o_aborted     = (state_reg == ST_ABORT);
    assign o_err         = (state_reg == ST_ERR);
    assign o_periods     = periods_reg;

endmodule
